// File: rtl/rpsc_pkg.sv
// Shared types for the cascaded supply interlock.
// Stage FSM encoding and its width.
package rpsc_pkg;

  localparam int unsigned ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    IDLE = 3'd0,
    PERM = 3'd1,
    RAMP = 3'd2,
    OK   = 3'd3,
    TRIP = 3'd4
  } stage_state_t;

endpackage

// File: rtl/rpsc_stage.sv
// One supply stage: permit FSM, OK-delay counter,
// and trip-cause capture.
module rpsc_stage
  import rpsc_pkg::*;
#(
  parameter int NF    = 8,
  parameter int TW    = 22,
  parameter bit LATCH = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [NF-1:0] i_fault,
  input  logic [NF-1:0] i_mask,
  input  logic [TW-1:0] i_ok_delay,
  input  logic         i_ps_act,
  input  logic         i_up_ok,
  input  logic         i_ack,
  output stage_state_t o_state,
  output logic [NF-1:0] o_cause
);

  stage_state_t  r_state;
  stage_state_t  w_next;
  logic [TW-1:0] r_cnt;
  logic [NF-1:0] w_masked;
  logic          w_fault_any;
  logic [TW-1:0] w_limit;
  logic          w_done;
  logic          w_trip_exit;

  assign w_masked    = i_fault & ~i_mask;
  assign w_fault_any = |w_masked;
  // A zero delay is treated as a one-cycle delay
  assign w_limit = (i_ok_delay == '0) ? '0
                 : i_ok_delay - 1'b1;
  assign w_done  = (r_cnt >= w_limit);

  assign w_trip_exit = LATCH ? (i_ack && !w_fault_any)
                             : !w_fault_any;

  always_comb begin
    w_next = r_state;
    if (r_state == TRIP) begin
      if (w_trip_exit) w_next = IDLE;
    end else if (w_fault_any) begin
      w_next = TRIP;
    end else if (!i_up_ok) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: w_next = PERM;
        PERM: if (i_ps_act) w_next = RAMP;
        RAMP: begin
          if (!i_ps_act)   w_next = PERM;
          else if (w_done) w_next = OK;
        end
        OK:   if (!i_ps_act) w_next = PERM;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Counts only while staying in RAMP; saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == RAMP && w_next == RAMP) begin
      if (!(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cause <= '0;
    end else if (w_next == TRIP) begin
      if (r_state != TRIP) o_cause <= w_masked;
    end else begin
      o_cause <= '0;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/rpsc_interlock.sv
// Cascaded supply interlock: NUM_STAGES stages chained
// by upstream OK, with a synchronised reset release.
module rpsc_interlock
  import rpsc_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int NUM_FAULTS  = 8,
  parameter int TIMER_WIDTH = 22,
  parameter bit LATCH_ALARM = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUM_STAGES*NUM_FAULTS-1:0]  fault,
  input  logic [NUM_STAGES*NUM_FAULTS-1:0]  fault_mask,
  input  logic [NUM_STAGES*TIMER_WIDTH-1:0] ok_delay,
  input  logic [NUM_STAGES-1:0] ps_act,
  input  logic [NUM_STAGES-1:0] u_low,
  input  logic                  ack,
  output logic [NUM_STAGES-1:0] on_perm,
  output logic [NUM_STAGES-1:0] not_alarm,
  output logic [NUM_STAGES-1:0] not_ok,
  output logic [NUM_STAGES-1:0] not_u_low,
  output logic [NUM_STAGES*NUM_FAULTS-1:0] trip_cause,
  output logic [NUM_STAGES*ST_W-1:0]       state
);

  logic [1:0]      r_rst_q;
  logic            w_rst_n;
  logic [NUM_STAGES-1:0] w_up;
  stage_state_t    w_st [NUM_STAGES];

  // Assert asynchronously, release on the second clock edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_q <= 2'b00;
    end else begin
      r_rst_q <= {r_rst_q[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_q[1];

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_up[k] = 1'b1;
    end else begin : g_chain
      assign w_up[k] = (w_st[k-1] == OK);
    end

    rpsc_stage #(
      .NF    (NUM_FAULTS),
      .TW    (TIMER_WIDTH),
      .LATCH (LATCH_ALARM)
    ) u_stage (
      .clk        (clk),
      .rst_n      (w_rst_n),
      .i_fault    (fault[k*NUM_FAULTS +: NUM_FAULTS]),
      .i_mask     (fault_mask[k*NUM_FAULTS +: NUM_FAULTS]),
      .i_ok_delay (ok_delay[k*TIMER_WIDTH +: TIMER_WIDTH]),
      .i_ps_act   (ps_act[k]),
      .i_up_ok    (w_up[k]),
      .i_ack      (ack),
      .o_state    (w_st[k]),
      .o_cause    (trip_cause[k*NUM_FAULTS +: NUM_FAULTS])
    );

    assign on_perm[k]   = (w_st[k] == PERM) || (w_st[k] == RAMP)
                       || (w_st[k] == OK);
    assign not_alarm[k] = (w_st[k] != TRIP);
    assign not_ok[k]    = (w_st[k] != OK);
    assign not_u_low[k] = !((w_st[k] == OK) && u_low[k]);
    assign state[k*ST_W +: ST_W] = w_st[k];
  end

endmodule

// File: tb/tb_rpsc_interlock.sv
// Directed bench for rpsc_interlock: latched and self-clearing
// instances checked every cycle against a countdown model.
module tb_rpsc_interlock;
  import rpsc_pkg::*;

  localparam int NS = 2;
  localparam int NF = 4;
  localparam int TW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic [NS*NF-1:0] fault = '0;
  logic [NS*NF-1:0] fault_mask = '0;
  logic [NS*TW-1:0] ok_delay = {22'd8, 22'd8};
  logic [NS-1:0] ps_act = '0;
  logic [NS-1:0] u_low = '0;
  logic ack = 1'b0;

  logic [NS-1:0] a_perm, a_alarm_n, a_ok_n, a_ul_n;
  logic [NS-1:0] b_perm, b_alarm_n, b_ok_n, b_ul_n;
  logic [NS*NF-1:0] a_cause, b_cause;
  logic [NS*3-1:0]  a_state, b_state;

  rpsc_interlock #(
    .NUM_STAGES(NS), .NUM_FAULTS(NF),
    .TIMER_WIDTH(TW), .LATCH_ALARM(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .fault(fault),
    .fault_mask(fault_mask), .ok_delay(ok_delay),
    .ps_act(ps_act), .u_low(u_low), .ack(ack),
    .on_perm(a_perm), .not_alarm(a_alarm_n),
    .not_ok(a_ok_n), .not_u_low(a_ul_n),
    .trip_cause(a_cause), .state(a_state)
  );

  rpsc_interlock #(
    .NUM_STAGES(NS), .NUM_FAULTS(NF),
    .TIMER_WIDTH(TW), .LATCH_ALARM(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .fault(fault),
    .fault_mask(fault_mask), .ok_delay(ok_delay),
    .ps_act(ps_act), .u_low(u_low), .ack(ack),
    .on_perm(b_perm), .not_alarm(b_alarm_n),
    .not_ok(b_ok_n), .not_u_low(b_ul_n),
    .trip_cause(b_cause), .state(b_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: index 0 = latched instance, 1 = self-clearing
  int         m_st    [2][NS];
  int         m_left  [2][NS];
  logic [3:0] m_cause [2][NS];
  int         m_hold = 2;

  task automatic model_clear();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < NS; k++) begin
        m_st[i][k] = IDLE;
        m_left[i][k] = 0;
        m_cause[i][k] = '0;
      end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int old [NS];
      for (int k = 0; k < NS; k++) old[k] = m_st[i][k];
      for (int k = 0; k < NS; k++) begin
        logic [3:0] mf;
        bit up, fa, ps;
        int d;
        up = (k == 0) || (old[k-1] == OK);
        mf = fault[k*NF +: NF] & ~fault_mask[k*NF +: NF];
        fa = (mf != 0);
        ps = ps_act[k];
        d  = int'(ok_delay[k*TW +: TW]);
        if (d == 0) d = 1;
        if (old[k] == TRIP) begin
          if ((i == 0) ? (ack && !fa) : !fa) begin
            m_st[i][k] = IDLE;
            m_cause[i][k] = '0;
          end
        end else if (fa) begin
          m_st[i][k] = TRIP;
          m_cause[i][k] = mf;
        end else if (!up) begin
          m_st[i][k] = IDLE;
        end else if (old[k] == IDLE) begin
          m_st[i][k] = PERM;
        end else if (old[k] == PERM) begin
          if (ps) begin
            m_st[i][k] = RAMP;
            m_left[i][k] = d;
          end
        end else if (old[k] == RAMP) begin
          if (!ps) m_st[i][k] = PERM;
          else begin
            m_left[i][k]--;
            if (m_left[i][k] <= 0) m_st[i][k] = OK;
          end
        end else if (!ps) begin
          m_st[i][k] = PERM;
        end
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_clear();
      m_hold = 2;
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      model_step();
    end
  end

  function automatic logic [21:0] model_bus(input int i);
    logic [1:0] p, al, ok, ul;
    logic [7:0] c;
    logic [5:0] s;
    for (int k = 0; k < NS; k++) begin
      int st;
      st = m_st[i][k];
      p[k]  = (st == PERM) || (st == RAMP) || (st == OK);
      al[k] = (st != TRIP);
      ok[k] = (st != OK);
      ul[k] = !((st == OK) && u_low[k]);
      c[k*NF +: NF] = m_cause[i][k];
      s[k*3 +: 3]   = 3'(st);
    end
    return {p, al, ok, ul, c, s};
  endfunction

  wire [21:0] a_bus = {a_perm, a_alarm_n, a_ok_n, a_ul_n,
                       a_cause, a_state};
  wire [21:0] b_bus = {b_perm, b_alarm_n, b_ok_n, b_ul_n,
                       b_cause, b_state};

  always @(negedge clk) begin
    logic [21:0] ea, eb;
    ea = model_bus(0);
    eb = model_bus(1);
    n_vec++;
    if (a_bus !== ea) begin
      n_err++;
      $display("FAIL bus_latched t=%0t got=%h exp=%h",
               $time, a_bus, ea);
    end
    n_vec++;
    if (b_bus !== eb) begin
      n_err++;
      $display("FAIL bus_selfclr t=%0t got=%h exp=%h",
               $time, b_bus, eb);
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Edges until latched-instance not_ok[idx] goes low
  task automatic wait_ok(input string nm, input int idx,
                         input int exp);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (a_ok_n[idx] == 1'b0) begin
        n = i;
        break;
      end
    end
    #1;
    check(nm, n, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lowc;
    #1 reset = 1'b0;
    #2;
    check("rst_perm", a_perm, 2'b00);
    check("rst_alarm", a_alarm_n, 2'b11);
    check("rst_ok", {a_ok_n, a_ul_n}, 4'b1111);
    check("rst_state", a_state, 6'd0);
    tick(2);
    reset = 1'b1;
    tick(4);

    // Bring-up with undervoltage flagged on stage 1
    ps_act[0] = 1'b1;
    wait_ok("bringup_s0", 0, 9);
    tick(2);
    ps_act[1] = 1'b1;
    u_low[1] = 1'b1;
    tick(3);
    check("ulow_ramp", a_ul_n[1], 1'b1);
    wait_ok("bringup_s1", 1, 6);
    check("ulow_ok", a_ul_n[1], 1'b0);
    u_low[1] = 1'b0;
    tick(1);

    // Latched trip on stage 0 fault line 1
    fault[1] = 1'b1;
    tick(2);
    check("trip_alarm", a_alarm_n, 2'b10);
    check("trip_cause", a_cause[3:0], 4'b0010);
    check("trip_perm", a_perm, 2'b00);
    ack = 1'b1;
    tick(3);
    check("ack_w_fault", a_state[2:0], 3'd4);
    ack = 1'b0;
    fault[1] = 1'b0;
    tick(2);
    check("held_no_ack", a_alarm_n[0], 1'b0);
    check("selfclr_out", b_alarm_n, 2'b11);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("ack_idle", a_state[2:0], 3'd0);
    tick(30);
    check("rebuilt_ok", a_ok_n, 2'b00);

    // Masked fault line has no effect
    fault_mask[1] = 1'b1;
    fault[1] = 1'b1;
    tick(4);
    check("mask_alarm", a_alarm_n, 2'b11);
    check("mask_ok", a_ok_n, 2'b00);
    fault[1] = 1'b0;
    fault_mask[1] = 1'b0;
    tick(1);

    // Three-cycle fault pulse
    fault[2] = 1'b1;
    lowc = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (b_alarm_n[0] == 1'b0) lowc++;
      if (i == 3) fault[2] = 1'b0;
    end
    #1;
    check("pulse_low", lowc, 3);
    check("pulse_clear", b_alarm_n, 2'b11);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(30);

    // Ramp abort at count 5, then full delay again
    ps_act[0] = 1'b0;
    tick(3);
    ps_act[0] = 1'b1;
    tick(6);
    ps_act[0] = 1'b0;
    tick(1);
    check("abort_perm", a_state[2:0], 3'd1);
    tick(2);
    ps_act[0] = 1'b1;
    wait_ok("reramp_s0", 0, 9);
    tick(4);

    // Asynchronous reset with stage 1 mid-ramp
    check("pre_rst_ramp", a_state[5:3], 3'd2);
    reset = 1'b0;
    #1;
    check("arst_perm", a_perm, 2'b00);
    check("arst_alarm", a_alarm_n, 2'b11);
    check("arst_state", a_state, 6'd0);
    ps_act = '0;
    ok_delay[TW-1:0] = '0;
    tick(2);
    reset = 1'b1;
    tick(4);

    // Zero delay behaves as one
    ps_act[0] = 1'b1;
    wait_ok("delay_zero", 0, 2);

    // Fault while stage 1 is still IDLE
    fault[4] = 1'b1;
    tick(1);
    check("idle_trip", a_alarm_n, 2'b01);
    check("idle_cause", a_cause[7:4], 4'b0001);
    fault[4] = 1'b0;
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(12);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rpsc_interlock.md
RPSC_INTERLOCK -- requirements
Module: rpsc_interlock

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 2: number of cascaded supply stages (stage 0 = G1, stage 1 = anode).
REQ-002 SHALL have parameter NUM_FAULTS, default 8: fault inputs per stage.
REQ-003 SHALL have parameter TIMER_WIDTH, default 22: OK-delay counter width.
REQ-004 SHALL have parameter LATCH_ALARM, default 1: 1 = trip held until ack, 0 = self-clearing.
REQ-005 clk  input  1  single system clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 fault  input  NUM_STAGES*NUM_FAULTS  per-stage fault lines, 1 = fault; stage k at [k*NUM_FAULTS +: NUM_FAULTS].
REQ-008 fault_mask  input  NUM_STAGES*NUM_FAULTS  1 = ignore that fault line.
REQ-009 ok_delay  input  NUM_STAGES*TIMER_WIDTH  per-stage OK delay in cycles.
REQ-010 ps_act  input  NUM_STAGES  supply-active feedback per stage.
REQ-011 u_low  input  NUM_STAGES  undervoltage flag per stage.
REQ-012 ack  input  1  alarm acknowledge, common to all stages.
REQ-013 on_perm  output  NUM_STAGES  1 = stage permitted to run.
REQ-014 not_alarm  output  NUM_STAGES  0 = stage in TRIP.
REQ-015 not_ok  output  NUM_STAGES  0 = stage reached OK.
REQ-016 not_u_low  output  NUM_STAGES  0 = undervoltage while OK.
REQ-017 trip_cause  output  NUM_STAGES*NUM_FAULTS  masked fault vector captured at trip.
REQ-018 state  output  NUM_STAGES*3  per-stage FSM state, debug.

Function
REQ-019 fault_any[k] SHALL be the OR of fault[k] & ~fault_mask[k], combinational.
REQ-020 Each stage SHALL run FSM IDLE, PERM, RAMP, OK, TRIP; upstream_ok[0] = 1, upstream_ok[k] = (state[k-1] == OK).
REQ-021 Transition priority SHALL be fault_any -> TRIP > !upstream_ok -> IDLE > ps_act transitions, from every state except TRIP.
REQ-022 Transitions: IDLE->PERM when upstream_ok; PERM->RAMP on ps_act; RAMP->OK when counter reaches max(ok_delay,1)-1 with ps_act high; RAMP/OK->PERM when ps_act drops.
REQ-023 Counter SHALL clear on every RAMP entry, increment each RAMP cycle, be held at 0 outside RAMP, never wrap; ok_delay=0 SHALL behave as 1.
REQ-024 Latency: ps_act rising at edge n with ok_delay=D -> not_ok low after edge n+1+D.
REQ-025 TRIP exit, LATCH_ALARM=1: -> IDLE only when ack=1 and fault_any=0 in the same cycle; ack with a fault present SHALL be ignored.
REQ-026 TRIP exit, LATCH_ALARM=0: -> IDLE on the first cycle fault_any=0; ack ignored.
REQ-027 trip_cause[k] SHALL load the masked fault vector on TRIP entry, hold while in TRIP, and clear on exit.
REQ-028 Outputs SHALL decode registered state only: on_perm = PERM|RAMP|OK; not_alarm = !TRIP; not_ok = !OK; not_u_low = !(OK & u_low).
REQ-029 Cascade: stage k leaving OK SHALL force stage k+1 to IDLE one cycle later (one cycle per stage); it SHALL NOT trip.
REQ-030 A fault on stage k SHALL trip stage k only; downstream stages go IDLE.
REQ-031 A fault during IDLE SHALL enter TRIP; fault at edge n -> not_alarm low after edge n+1.

Reset
REQ-032 reset low SHALL asynchronously force all stages to IDLE, counters 0, and trip_cause 0.
REQ-033 Reset values SHALL be: on_perm 0, not_alarm all 1, not_ok all 1, not_u_low all 1, state all IDLE.
REQ-034 reset mid-RAMP or in TRIP SHALL discard progress and latched alarms; deassertion SHALL be synchronised internally.

Structure
REQ-035 Package rpsc_pkg SHALL hold the stage_state_t enum (IDLE=0, PERM=1, RAMP=2, OK=3, TRIP=4) and state-width constant.
REQ-036 One sub-module, rpsc_stage, SHALL contain a single stage's FSM, counter, and trip capture; the top generates NUM_STAGES instances and the upstream_ok chain.

Verification (NUM_STAGES=2, NUM_FAULTS=4, ok_delay=8 both)
REQ-037 Bring-up: no faults, ps_act[0]=1, then ps_act[1]=1 -> stage0 not_ok low 9 cycles after ps_act[0]; then stage1 not_ok low 9 cycles after its ps_act.
REQ-038 Latched trip: fault[1]=1 on stage 0 while both OK -> stage0 TRIP, trip_cause[3:0]=0010, on_perm=00 within 2 cycles; ack while fault held -> no change; fault clear + ack -> IDLE.
REQ-039 Mask: fault_mask[1]=1 then fault[1]=1 -> no trip, outputs unchanged.
REQ-040 Self-clear (LATCH_ALARM=0): 3-cycle fault pulse -> not_alarm low for 3 cycles, then IDLE without ack.
REQ-041 ps_act[0] drop at counter 5 -> PERM, counter 0; reassert -> full 8-cycle delay again; async reset mid-RAMP -> all outputs at reset values immediately.
REQ-042 Undervoltage: u_low[1]=1 in RAMP -> not_u_low stays 1; in OK -> not_u_low[1]=0.
